// File: rtl/rcv_fifo_buf_if.sv
// Receive FIFO bus: producer write side, consumer read side and status.
// master = producer/consumer logic, slave = the FIFO itself.
interface rcv_fifo_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  sync_clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            tail_side;
    logic [1:0]            head_side;
    logic [2:0]            count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output sync_clr, wr_en, wr_data, rd_en,
        input  rd_data, tail_side, head_side, count,
        input  full, empty, overflow, underflow
    );

    modport slave (
        input  sync_clr, wr_en, wr_data, rd_en,
        output rd_data, tail_side, head_side, count,
        output full, empty, overflow, underflow
    );
endinterface

// File: rtl/rcv_fifo_buf.sv
// rcv_fifo_buf: 4-entry first-word-fall-through receive FIFO between the
// receive decode stage and packet assembly.
// Optional build macro RCV_FIFO_STICKY_ERR_EN: when defined, overflow and
// underflow hold until rst or sync_clr; otherwise they are one-cycle pulses.
module rcv_fifo_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    rcv_fifo_buf_if.slave bus
);
    localparam int DEPTH = 4;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            tail_q;
    logic [1:0]            head_q;
    logic [2:0]            count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;
    logic wr_refused;
    logic rd_refused;
    logic flush;

    // Status comes only from the registered count, never from inputs.
    always_comb begin
        full  = (count_q == 3'(DEPTH));
        empty = (count_q == 3'd0);
    end

    // Accept decisions; a pop in the same cycle frees a slot for a write.
    always_comb begin
        flush      = rst | bus.sync_clr;
        rd_acc     = bus.rd_en & ~empty;
        wr_acc     = bus.wr_en & (~full | rd_acc);
        wr_refused = bus.wr_en & ~wr_acc;
        rd_refused = bus.rd_en & empty;
    end

    // Storage: contents are don't-care after flush, so no reset term.
    always_ff @(posedge clk) begin
        if (!flush && wr_acc)
            mem[tail_q] <= bus.wr_data;
    end

    // Pointers and occupancy; both pointers wrap naturally in 2 bits.
    always_ff @(posedge clk) begin
        if (flush) begin
            tail_q  <= 2'd0;
            head_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (wr_acc)
                tail_q <= tail_q + 2'd1;
            if (rd_acc)
                head_q <= head_q + 2'd1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Error flags; pending requests during a flush never raise them.
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
`ifdef RCV_FIFO_STICKY_ERR_EN
            overflow_q  <= overflow_q  | wr_refused;
            underflow_q <= underflow_q | rd_refused;
`else
            overflow_q  <= wr_refused;
            underflow_q <= rd_refused;
`endif
        end
    end

    // Outputs: head word falls through combinationally.
    always_comb begin
        bus.rd_data   = mem[head_q];
        bus.tail_side = tail_q;
        bus.head_side = head_q;
        bus.count     = count_q;
        bus.full      = full;
        bus.empty     = empty;
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end
endmodule

// File: tb/tb_rcv_fifo_buf.sv
// Bench for rcv_fifo_buf: directed vector table, then randomized traffic
// against a queue-based reference model.
module tb_rcv_fifo_buf;
`ifdef RCV_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rcv_fifo_buf_if #(.DATA_WIDTH(32)) bus ();
    rcv_fifo_buf #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit rst; bit clr; bit we; logic [31:0] wd; bit re;
        int cnt; int t; int h;
        bit o; bit u; bit os; bit us;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit c, bit we, logic [31:0] wd, bit re,
                               int cnt, int t, int h, bit o, bit u, bit os, bit us,
                               logic [31:0] d);
        vec_t x;
        x.rst = r; x.clr = c; x.we = we; x.wd = wd; x.re = re;
        x.cnt = cnt; x.t = t; x.h = h; x.o = o; x.u = u; x.os = os; x.us = us; x.d = d;
        return x;
    endfunction

    task automatic drive(bit r, bit c, bit we, logic [31:0] wd, bit re);
        rst = r; bus.sync_clr = c; bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
    endtask

    task automatic check(string name, int cnt, int t, int h, bit o, bit u, logic [31:0] d);
        bit ok;
        ok = (int'(bus.count) == cnt) && (int'(bus.tail_side) == t) &&
             (int'(bus.head_side) == h) && (bus.full == (cnt == 4)) &&
             (bus.empty == (cnt == 0)) && (bus.overflow == o) && (bus.underflow == u) &&
             (cnt == 0 || bus.rd_data == d);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d t=%0d h=%0d f=%b e=%b o=%b u=%b d=%h; want cnt=%0d t=%0d h=%0d f=%b e=%b o=%b u=%b d=%h",
                     name, bus.count, bus.tail_side, bus.head_side, bus.full, bus.empty,
                     bus.overflow, bus.underflow, bus.rd_data,
                     cnt, t, h, cnt == 4, cnt == 0, o, u, d);
        end
    endtask

    // Reference model: a plain queue plus modulo-4 slot counters.
    logic [31:0] mq[$];
    int m_t = 0, m_h = 0;
    bit m_o = 0, m_u = 0;

    task automatic mstep(string name, bit r, bit c, bit we, logic [31:0] wd, bit re);
        bit racc, wacc, po, pu;
        drive(r, c, we, wd, re);
        if (r || c) begin
            mq.delete(); m_t = 0; m_h = 0; m_o = 0; m_u = 0;
        end else begin
            racc = re && (mq.size() > 0);
            wacc = we && (mq.size() < 4 || racc);
            po = we && !wacc;
            pu = re && (mq.size() == 0);
            if (racc) begin void'(mq.pop_front()); m_h = (m_h + 1) % 4; end
            if (wacc) begin mq.push_back(wd); m_t = (m_t + 1) % 4; end
            m_o = STICKY ? (m_o | po) : po;
            m_u = STICKY ? (m_u | pu) : pu;
        end
        @(posedge clk); #1;
        check(name, mq.size(), m_t, m_h, m_o, m_u, (mq.size() > 0) ? mq[0] : 32'h0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        //        rst clr we  wd            re  cnt t h  o u os us  d
        vecs.push_back(v(1,0,0,32'h0 ,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,0,32'h0 ,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,1,32'hA0,0, 1,1,0, 0,0,0,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA1,0, 2,2,0, 0,0,0,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA2,0, 3,3,0, 0,0,0,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA3,0, 4,0,0, 0,0,0,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hB0,0, 4,0,0, 1,0,1,0, 32'hA0));
        vecs.push_back(v(0,0,0,32'h0 ,1, 3,0,1, 0,0,1,0, 32'hA1));
        vecs.push_back(v(0,0,0,32'h0 ,1, 2,0,2, 0,0,1,0, 32'hA2));
        vecs.push_back(v(0,0,0,32'h0 ,1, 1,0,3, 0,0,1,0, 32'hA3));
        vecs.push_back(v(0,0,0,32'h0 ,1, 0,0,0, 0,0,1,0, 32'h0 ));
        vecs.push_back(v(0,0,1,32'hA0,0, 1,1,0, 0,0,1,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA1,0, 2,2,0, 0,0,1,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA2,0, 3,3,0, 0,0,1,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hA3,0, 4,0,0, 0,0,1,0, 32'hA0));
        vecs.push_back(v(0,0,1,32'hC0,1, 4,1,1, 0,0,1,0, 32'hA1));
        vecs.push_back(v(0,0,0,32'h0 ,1, 3,1,2, 0,0,1,0, 32'hA2));
        vecs.push_back(v(0,0,0,32'h0 ,1, 2,1,3, 0,0,1,0, 32'hA3));
        vecs.push_back(v(0,0,0,32'h0 ,1, 1,1,0, 0,0,1,0, 32'hC0));
        vecs.push_back(v(0,0,0,32'h0 ,1, 0,1,1, 0,0,1,0, 32'h0 ));
        vecs.push_back(v(0,1,0,32'h0 ,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,1,32'hD0,1, 1,1,0, 0,1,0,1, 32'hD0));
        vecs.push_back(v(0,0,0,32'h0 ,0, 1,1,0, 0,0,0,1, 32'hD0));
        vecs.push_back(v(0,1,0,32'h0 ,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,1,32'hE0,0, 1,1,0, 0,0,0,0, 32'hE0));
        vecs.push_back(v(0,0,1,32'hE1,0, 2,2,0, 0,0,0,0, 32'hE0));
        vecs.push_back(v(0,1,1,32'hE2,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,1,32'hF0,0, 1,1,0, 0,0,0,0, 32'hF0));
        vecs.push_back(v(1,0,1,32'hF1,0, 0,0,0, 0,0,0,0, 32'h0 ));
        vecs.push_back(v(0,0,0,32'h0 ,1, 0,0,0, 0,1,0,1, 32'h0 ));
        vecs.push_back(v(1,0,0,32'h0 ,0, 0,0,0, 0,0,0,0, 32'h0 ));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].re);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].t, vecs[i].h,
                  STICKY ? vecs[i].os : vecs[i].o, STICKY ? vecs[i].us : vecs[i].u, vecs[i].d);
        end

        // Hand sequence: fill, then hold wr+rd at full; then wr+rd while empty.
        mstep("seq_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) mstep("seq_fill", 0, 0, 1, 32'h100 + i, 0);
        for (int i = 0; i < 6; i++) mstep("seq_full_rw", 0, 0, 1, 32'h200 + i, 1);
        for (int i = 0; i < 4; i++) mstep("seq_drain", 0, 0, 0, 0, 1);
        mstep("seq_empty_rw", 0, 0, 1, 32'h300, 1);
        mstep("seq_idle", 0, 0, 0, 0, 0);
        mstep("seq_over_rd", 0, 0, 0, 0, 1);
        mstep("seq_under", 0, 0, 0, 0, 1);

        // Randomized traffic with phases biased toward fill and drain.
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = ((i / 50) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            mstep("rand",
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < wp,
                  $urandom,
                  $urandom_range(0, 99) < rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rcv_fifo_buf.md
Name: rcv_fifo_buf

Overview:
- 4-entry receive FIFO that holds data words in the receive path.
- The tail pointer is a 2-bit wrap-around index (slot 0..3). It advances on each accepted write and clears on flush, so the tail is always the next slot to be written.
- Adds a head pointer, an occupancy count, full/empty flags and error flags, so downstream packet logic can drain words in order.
- Sits between the receive shift/decode stage (producer) and the packet assembly logic (consumer).

Parameters:
- DATA_WIDTH, 32, width of each stored word.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled only on rising clk.
- sync_clr  input  1  synchronous flush: empties the FIFO and zeroes both pointers.
- wr_en  input  1  producer write request.
- wr_data  input  DATA_WIDTH  word to store.
- rd_en  input  1  consumer read/pop request.
- rd_data  output  DATA_WIDTH  word at the head slot (first-word-fall-through).
- tail_side  output  2  next write slot index.
- head_side  output  2  next read slot index.
- count  output  3  occupancy, 0..4.
- full  output  1  high when count==4.
- empty  output  1  high when count==0.
- overflow  output  1  a write was refused.
- underflow  output  1  a read was refused.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - tail_side=0, head_side=0, count=0
  - empty=1, full=0, overflow=0, underflow=0
  - storage contents are don't-care
- rst has priority over sync_clr, which has priority over wr_en/rd_en.
- sync_clr=1 gives the same pointer, count and flag result as reset. Pending wr_en/rd_en in that cycle are ignored and do not set error flags.
- Read accept: rd_acc = rd_en & ~empty.
- Write accept: wr_acc = wr_en & (~full | rd_acc). A simultaneous pop frees a slot, so a write while full is legal in the same cycle as a read.
- On wr_acc:
  - mem[tail_side] <= wr_data
  - tail_side <= tail_side+1, mod 4 (3 wraps to 0)
- On rd_acc: head_side <= head_side+1, mod 4.
- Count update:
  - wr_acc only: count+1
  - rd_acc only: count-1
  - both or neither: unchanged
- full and empty are decoded from the registered count, so there is no combinational path from inputs.
- rd_data = mem[head_side] combinationally (FWFT). It is valid whenever empty=0 and undefined when empty=1.
- Write latency: a word written at edge N is visible on rd_data after edge N if the FIFO was empty. empty drops on that same edge.
- Refused operations:
  - wr_en & ~wr_acc sets overflow; storage, tail_side and count are unchanged.
  - rd_en & empty sets underflow; head_side is unchanged.
- Empty with both wr_en and rd_en: the write is accepted and the read is refused (underflow=1). count ends at 1 and rd_data shows the new word.
- Full with both: both are accepted, count stays 4 and both pointers advance.
- Pointer invariant: (tail_side - head_side) mod 4 == count mod 4. The count==4 vs count==0 ambiguity is resolved only by count.

Optional Feature:
- Macro RCV_FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Once set they stay high until rst or sync_clr.
- Undefined: overflow and underflow are single-cycle pulses. Each is high for exactly the cycle after the refused request and is cleared on the next edge unless re-triggered.
- FIFO data and pointer behaviour are identical in both builds.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, tail_side=0, head_side=0, flags 0.
- Write 0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> count=4, full=1, tail_side=0 (wrapped), rd_data=0xA0.
- From full, write 0xB0 with rd_en=0 -> overflow=1, count=4. Then pop 4 -> rd_data sequence 0xA0..0xA3, empty=1, head_side=0.
- From full, simultaneous wr 0xC0 + rd -> count=4, head_side=1, tail_side=1. Drain -> 0xA1,0xA2,0xA3,0xC0.
- From empty, simultaneous wr 0xD0 + rd -> underflow=1, count=1, rd_data=0xD0. Pulse build: underflow=0 next cycle. Sticky build: underflow stays 1 until sync_clr.
- After 2 writes, assert sync_clr together with wr_en -> count=0, pointers 0, empty=1, no overflow. Repeat with rst=1 mid-stream -> same reset state.
